// File: rtl/updown_counter_bcd2.sv
// Up/down modulo counter with a clock-enable prescaler, wrap/saturate
// boundary handling, and a registered two-digit active-low 7-segment display.
module updown_counter_bcd2 #(
  parameter int WIDTH      = 7,
  parameter int MAX        = 15,
  parameter int PRESET_VAL = 15,
  parameter int DIV_BITS   = 23,
  parameter int BLANK_LZ   = 0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             preset,
  input  logic             enable,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1
);

  localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] PRESET_CNT = WIDTH'(PRESET_VAL);
  localparam logic [0:6]       SEG_ZERO   = 7'b0000001;
  localparam logic [0:6]       SEG_BLANK  = 7'b1111111;

  logic [DIV_BITS-1:0] prescaler;
  logic                wrap_point;
  logic [WIDTH-1:0]    tens;
  logic [WIDTH-1:0]    units;

  // Segment pattern for one decimal digit; anything above 9 is dark.
  function automatic logic [0:6] seg7(input logic [WIDTH-1:0] d);
    case (int'(d))
      0:       seg7 = 7'b0000001;
      1:       seg7 = 7'b1001111;
      2:       seg7 = 7'b0010010;
      3:       seg7 = 7'b0000110;
      4:       seg7 = 7'b1001100;
      5:       seg7 = 7'b0100100;
      6:       seg7 = 7'b0100000;
      7:       seg7 = 7'b0001111;
      8:       seg7 = 7'b0000000;
      9:       seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign wrap_point = &prescaler;

  // Prescaler, tick, step and terminal-count pulse; the step decision is taken
  // on the same edge that raises tick, so tick, tc and the new count coincide.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else if (preset) begin
      count     <= PRESET_CNT;
      prescaler <= '0;
      tick      <= 1'b0;
      tc        <= 1'b0;
    end else begin
      prescaler <= prescaler + DIV_BITS'(1);
      tick      <= wrap_point;
      tc        <= 1'b0;
      if (wrap_point && enable) begin
        if (up) begin
          if (count == MAX_VAL) begin
            tc <= 1'b1;
            if (!sat_mode) count <= '0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            tc <= 1'b1;
            if (!sat_mode) count <= MAX_VAL;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

  // Decimal split of the current count for the display.
  always_comb begin
    tens  = count / WIDTH'(10);
    units = count - (tens * WIDTH'(10));
  end

  // Display registers, one cycle behind count; leading zero optionally blanked.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      HEX0 <= SEG_ZERO;
      HEX1 <= (BLANK_LZ != 0) ? SEG_BLANK : SEG_ZERO;
    end else begin
      HEX0 <= seg7(units);
      if ((BLANK_LZ != 0) && (tens == '0))
        HEX1 <= SEG_BLANK;
      else
        HEX1 <= seg7(tens);
    end
  end

endmodule

// File: tb/tb_updown_counter_bcd2.sv
// Table-driven bench for updown_counter_bcd2: two instances (default 0..15 and
// a 0..42 leading-zero-blanking variant), expected results queued per vector.
module tb_updown_counter_bcd2;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic       sel;
    logic       rst;
    logic       pre;
    logic       en;
    logic       up;
    logic       sat;
    int         cycles;
    int         exp_count;
    logic       exp_tick;
    logic       exp_tc;
    logic       chk_hex;
    logic [6:0] exp_hex0;
    logic [6:0] exp_hex1;
  } vec_t;

  logic       clk = 1'b0;
  logic       a_reset, a_preset, a_enable, a_up, a_sat;
  logic       b_reset, b_preset, b_enable, b_up, b_sat;
  logic [6:0] a_count, b_count;
  logic       a_tick, a_tc, b_tick, b_tc;
  logic [0:6] a_hex0, a_hex1, b_hex0, b_hex1;

  vec_t vecs[$];
  vec_t sb_queue[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  updown_counter_bcd2 #(
    .WIDTH(7), .MAX(15), .PRESET_VAL(15), .DIV_BITS(2), .BLANK_LZ(0)
  ) dut_a (
    .CLOCK_50(clk), .reset(a_reset), .preset(a_preset), .enable(a_enable),
    .up(a_up), .sat_mode(a_sat), .count(a_count), .tick(a_tick), .tc(a_tc),
    .HEX0(a_hex0), .HEX1(a_hex1)
  );

  updown_counter_bcd2 #(
    .WIDTH(7), .MAX(42), .PRESET_VAL(42), .DIV_BITS(2), .BLANK_LZ(1)
  ) dut_b (
    .CLOCK_50(clk), .reset(b_reset), .preset(b_preset), .enable(b_enable),
    .up(b_up), .sat_mode(b_sat), .count(b_count), .tick(b_tick), .tc(b_tc),
    .HEX0(b_hex0), .HEX1(b_hex1)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic addVec(input logic sel, input logic rst, input logic pre,
                        input logic en, input logic up, input logic sat,
                        input int cycles, input int exp_count,
                        input logic exp_tick, input logic exp_tc,
                        input logic chk_hex, input logic [6:0] exp_hex0,
                        input logic [6:0] exp_hex1);
    vec_t v;
    v.sel = sel; v.rst = rst; v.pre = pre; v.en = en; v.up = up; v.sat = sat;
    v.cycles = cycles; v.exp_count = exp_count; v.exp_tick = exp_tick;
    v.exp_tc = exp_tc; v.chk_hex = chk_hex; v.exp_hex0 = exp_hex0;
    v.exp_hex1 = exp_hex1;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input int row, input string name,
                            input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL row %0d %s: got %0d expected %0d", row, name, actual, expected);
    end
  endtask

  task automatic checkSeg(input int row, input string name,
                          input logic [6:0] actual, input logic [6:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL row %0d %s: got %b expected %b", row, name, actual, expected);
    end
  endtask

  // Drive one vector onto the selected DUT (the other is parked in reset),
  // queue its expectation, and let the requested number of edges pass.
  task automatic applyStimulus(input vec_t v);
    if (!v.sel) begin
      a_reset = v.rst; a_preset = v.pre; a_enable = v.en; a_up = v.up; a_sat = v.sat;
      b_reset = 1'b1;  b_preset = 1'b0;  b_enable = 1'b0; b_up = 1'b0; b_sat = 1'b0;
    end else begin
      b_reset = v.rst; b_preset = v.pre; b_enable = v.en; b_up = v.up; b_sat = v.sat;
      a_reset = 1'b1;  a_preset = 1'b0;  a_enable = 1'b0; a_up = 1'b0; a_sat = 1'b0;
    end
    sb_queue.push_back(v);
    repeat (v.cycles) @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare it with the selected DUT's outputs.
  task automatic checkOutput(input int row);
    vec_t e;
    if (sb_queue.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL row %0d scoreboard: got empty queue expected an entry", row);
      return;
    end
    e = sb_queue.pop_front();
    if (!e.sel) begin
      checkValue(row, "count", int'(a_count), e.exp_count);
      checkValue(row, "tick", int'(a_tick), int'(e.exp_tick));
      checkValue(row, "tc", int'(a_tc), int'(e.exp_tc));
      if (e.chk_hex) begin
        checkSeg(row, "HEX0", a_hex0, e.exp_hex0);
        checkSeg(row, "HEX1", a_hex1, e.exp_hex1);
      end
    end else begin
      checkValue(row, "count", int'(b_count), e.exp_count);
      checkValue(row, "tick", int'(b_tick), int'(e.exp_tick));
      checkValue(row, "tc", int'(b_tc), int'(e.exp_tc));
      if (e.chk_hex) begin
        checkSeg(row, "HEX0", b_hex0, e.exp_hex0);
        checkSeg(row, "HEX1", b_hex1, e.exp_hex1);
      end
    end
  endtask

  // Vector table, then apply/compare loop, then summary.
  initial begin
    a_reset = 1'b1; a_preset = 1'b0; a_enable = 1'b0; a_up = 1'b0; a_sat = 1'b0;
    b_reset = 1'b1; b_preset = 1'b0; b_enable = 1'b0; b_up = 1'b0; b_sat = 1'b0;

    //     sel rst pre en up sat cyc cnt tk tc hx hex0 hex1
    // Reset state and first tick (display still lags the count)
    addVec(0, 1, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  4,  1, 1, 0, 1, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  1,  1, 0, 0, 1, S1, S0);
    // Up to 15, then wrap to 0 with tc for one cycle
    addVec(0, 0, 0, 1, 1, 0, 51, 14, 1, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  4, 15, 1, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  1, 15, 0, 0, 1, S5, S1);
    addVec(0, 0, 0, 1, 1, 0,  3,  0, 1, 1, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, S0);
    // Down-wrap from 0 to 15, then an ordinary decrement
    addVec(0, 0, 0, 1, 0, 0,  3, 15, 1, 1, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 0,  4, 14, 1, 0, 0, S0, S0);
    // Down-saturate at 0: tc on every tick, count held
    addVec(0, 1, 0, 1, 0, 1,  1,  0, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 1,  4,  0, 1, 1, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 1,  1,  0, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 1,  3,  0, 1, 1, 0, S0, S0);
    // Preset, prescaler restart (first tick 4 clocks later), up-saturate at 15
    addVec(0, 0, 1, 1, 1, 1,  1, 15, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 1,  3, 15, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 1,  1, 15, 1, 1, 0, S0, S0);
    // Preset mid-count holds the count pinned
    addVec(0, 0, 0, 1, 0, 0,  4, 14, 1, 0, 0, S0, S0);
    addVec(0, 0, 1, 1, 0, 0,  2, 15, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 0,  3, 15, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 0, 0,  1, 14, 1, 0, 0, S0, S0);
    // Reset beats preset
    addVec(0, 1, 1, 1, 0, 0,  1,  0, 0, 0, 1, S0, S0);
    // Enable low: ticks continue, count and tc frozen
    addVec(0, 0, 0, 0, 1, 0,  4,  0, 1, 0, 0, S0, S0);
    addVec(0, 0, 0, 0, 1, 0,  1,  0, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 0, 1, 0,  3,  0, 1, 0, 0, S0, S0);
    addVec(0, 0, 0, 0, 0, 0,  4,  0, 1, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  4,  1, 1, 0, 0, S0, S0);
    // Reset with a tick pending discards it and restarts the prescaler
    addVec(0, 0, 0, 1, 1, 0,  3,  1, 0, 0, 0, S0, S0);
    addVec(0, 1, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  1,  0, 0, 0, 0, S0, S0);
    addVec(0, 0, 0, 1, 1, 0,  3,  1, 1, 0, 0, S0, S0);
    // MAX=42 instance with leading-zero blanking
    addVec(1, 1, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, SB);
    addVec(1, 0, 1, 1, 1, 0,  1, 42, 0, 0, 0, S0, S0);
    addVec(1, 0, 1, 1, 1, 0,  1, 42, 0, 0, 1, S2, S4);
    addVec(1, 1, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, SB);
    addVec(1, 0, 0, 1, 1, 0, 168, 42, 1, 0, 0, S0, S0);
    addVec(1, 0, 0, 1, 1, 0,  1, 42, 0, 0, 1, S2, S4);
    addVec(1, 0, 0, 1, 1, 0,  3,  0, 1, 1, 0, S0, S0);
    addVec(1, 0, 0, 1, 1, 0,  1,  0, 0, 0, 1, S0, SB);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
